// File: rtl/fma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fma_pkg
// Description : Shared constants and types for the 4-lane bf16 multiply-
//               accumulator and its read-out normalizer.
// Revision    : 1.0 - initial release
// ============================================================================
package fma_pkg;

    localparam int          BF16_EXP_BIAS = 127;
    localparam int          PROD_EXP_BIAS = 254;
    localparam logic [15:0] BF16_INF      = 16'h7F80;

    typedef logic [1:0] lane_idx_t;

    typedef struct packed {
        logic [31:0] acc;
        logic [9:0]  exp;
    } acc_lane_t;

endpackage
`default_nettype wire

// File: rtl/fmab_norm_lzc32.sv
`default_nettype none
// ============================================================================
// Module      : lzc32
// Description : Combinational 32-bit leading-zero count; all-zero input
//               yields 32.
// Revision    : 1.0 - initial release
// ============================================================================
module lzc32 (
    input  logic [31:0] i_data,
    output logic [5:0]  o_count
);

    // Ascending scan so the most significant set bit has the final word.
    always_comb begin
        o_count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (i_data[i]) begin
                o_count = 6'(31 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fmab_norm.sv
`default_nettype none
// ============================================================================
// Module      : fmab_norm
// Description : Captures a 4-lane accumulator set and converts it, one lane
//               per cycle, to bf16 (RNE) through a normalize/round pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module fmab_norm
    import fma_pkg::*;
#(
    parameter int FRAC_BITS = 14,
    parameter int NLANE     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] acc0,
    input  logic [31:0] acc1,
    input  logic [31:0] acc2,
    input  logic [31:0] acc3,
    input  logic [9:0]  exp0,
    input  logic [9:0]  exp1,
    input  logic [9:0]  exp2,
    input  logic [9:0]  exp3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [1:0]  out_lane,
    output logic        out_last
);

    localparam logic             c_ST_IDLE   = 1'b0;
    localparam logic             c_ST_BUSY   = 1'b1;
    localparam lane_idx_t        c_LAST_LANE = lane_idx_t'(NLANE - 1);
    // Folds the product bias, the bf16 bias and the binary point into one offset.
    localparam logic signed [11:0] c_E_OFS =
        12'(31 + BF16_EXP_BIAS - PROD_EXP_BIAS - FRAC_BITS);

    logic       r_state;
    lane_idx_t  r_cnt;
    logic       r_in_ready;
    acc_lane_t  r_buf [NLANE];

    logic              r_s1_valid;
    logic              r_s1_sign;
    logic [30:0]       r_s1_man;
    logic signed [11:0] r_s1_exp;
    logic              r_s1_zero;
    lane_idx_t         r_s1_lane;

    logic        r_out_valid;
    logic [15:0] r_out_data;
    lane_idx_t   r_out_lane;
    logic        r_out_last;

    logic              w_adv;
    logic              w_issue;
    acc_lane_t         w_lane;
    logic [31:0]       w_mag;
    logic [5:0]        w_lz;
    logic [30:0]       w_nrm;
    logic signed [11:0] w_exp_ext;
    logic signed [11:0] w_e_s1;
    logic              w_zero;

    logic [6:0]        w_m;
    logic              w_g;
    logic              w_s;
    logic              w_rnd;
    logic [7:0]        w_m_inc;
    logic signed [11:0] w_e_rnd;
    logic [15:0]       w_pack;

    assign w_adv   = !r_out_valid || out_ready;
    assign w_issue = (r_state == c_ST_BUSY) && w_adv;

    // ------------------------------------------------------------------
    // Capture/issue control
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            for (int i = 0; i < NLANE; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_buf[0]   <= '{acc: acc0, exp: exp0};
                        r_buf[1]   <= '{acc: acc1, exp: exp1};
                        r_buf[2]   <= '{acc: acc2, exp: exp2};
                        r_buf[3]   <= '{acc: acc3, exp: exp3};
                        r_cnt      <= '0;
                        r_state    <= c_ST_BUSY;
                        r_in_ready <= 1'b0;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    if (w_adv) begin
                        r_cnt <= r_cnt + lane_idx_t'(1);
                        if (r_cnt == c_LAST_LANE) begin
                            r_state    <= c_ST_IDLE;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;

    // ------------------------------------------------------------------
    // Stage 1: magnitude, leading-zero normalize, exponent
    // ------------------------------------------------------------------
    assign w_lane = r_buf[r_cnt];
    assign w_mag  = w_lane.acc[31] ? (~w_lane.acc + 32'd1) : w_lane.acc;

    lzc32 u_lzc (
        .i_data  (w_mag),
        .o_count (w_lz)
    );

    // The implicit leading one is dropped, so only the low 31 bits survive.
    assign w_nrm     = w_mag[30:0] << w_lz;
    assign w_exp_ext = {{2{w_lane.exp[9]}}, w_lane.exp};
    assign w_e_s1    = w_exp_ext + c_E_OFS - $signed({6'd0, w_lz});
    assign w_zero    = (w_mag == '0) || (w_lane.exp == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_man   <= '0;
            r_s1_exp   <= '0;
            r_s1_zero  <= 1'b0;
            r_s1_lane  <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_issue;
            if (w_issue) begin
                r_s1_sign <= w_lane.acc[31];
                r_s1_man  <= w_nrm;
                r_s1_exp  <= w_e_s1;
                r_s1_zero <= w_zero;
                r_s1_lane <= r_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round-to-nearest-even and pack
    // ------------------------------------------------------------------
    assign w_m     = r_s1_man[30:24];
    assign w_g     = r_s1_man[23];
    assign w_s     = |r_s1_man[22:0];
    assign w_rnd   = w_g && (w_s || w_m[0]);
    assign w_m_inc = {1'b0, w_m} + {7'd0, w_rnd};
    assign w_e_rnd = r_s1_exp + $signed({11'd0, w_m_inc[7]});

    always_comb begin
        w_pack = 16'h0000;
        if (r_s1_zero) begin
            w_pack = 16'h0000;
        end else if (w_e_rnd >= 12'sd255) begin
            w_pack = {r_s1_sign, BF16_INF[14:0]};
        end else if (w_e_rnd <= 12'sd0) begin
            w_pack = {r_s1_sign, 15'd0};
        end else begin
            // A mantissa carry leaves w_m_inc[6:0] at zero, as required.
            w_pack = {r_s1_sign, w_e_rnd[7:0], w_m_inc[6:0]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_lane  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_pack;
                r_out_lane <= r_s1_lane;
                r_out_last <= (r_s1_lane == c_LAST_LANE);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_lane  = r_out_lane;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire
